// File: rtl/rr_warp_issue_arbiter_if.sv
// Issue-slot handshake between the warp ready logic and the issue stage.
// master: the arbiter (drives the grant); slave: the issue/request side.
interface rr_warp_issue_arbiter_if #(
  parameter int NUM_WARP = 8,
  parameter int IDX_W    = 3,
  parameter int CNT_W    = 16
);
  logic [NUM_WARP-1:0] req;
  logic [NUM_WARP-1:0] warp_en;
  logic                flush;
  logic                grt_valid;
  logic [NUM_WARP-1:0] grt;
  logic [IDX_W-1:0]    grt_idx;
  logic                grt_ready;
  logic [CNT_W-1:0]    issue_cnt;

  modport master (
    input  req, warp_en, flush, grt_ready,
    output grt_valid, grt, grt_idx, issue_cnt
  );

  modport slave (
    output req, warp_en, flush, grt_ready,
    input  grt_valid, grt, grt_idx, issue_cnt
  );
endinterface

// File: rtl/rr_warp_issue_arbiter.sv
// Round-robin warp issue arbiter: registered one-hot grant held under a
// valid/ready handshake, rotating priority pointer, accepted-issue counter.

// Per-warp eligibility. elig_acc drops the warp currently holding the grant
// so an accepting warp cannot win the re-arbitration in the same cycle.
module rr_warp_issue_arbiter_lane (
  input  logic req,
  input  logic en,
  input  logic is_cur,
  output logic elig,
  output logic elig_acc
);
  assign elig     = req & en;
  assign elig_acc = req & en & ~is_cur;
endmodule

module rr_warp_issue_arbiter #(
  parameter int NUM_WARP = 8,
  parameter int IDX_W    = 3,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rr_warp_issue_arbiter_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [IDX_W:0]   NW   = (IDX_W+1)'(NUM_WARP);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WARP-1);

  state_t              state, state_n;
  logic                vld_q, vld_n;
  logic [NUM_WARP-1:0] grt_q, grt_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic [IDX_W-1:0]    ptr_q, ptr_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;

  logic [NUM_WARP-1:0] elig, elig_acc;
  logic [IDX_W-1:0]    ptr_acc;
  logic [IDX_W:0]      win_idle, win_acc;

  for (genvar i = 0; i < NUM_WARP; i++) begin : g_lane
    rr_warp_issue_arbiter_lane u_lane (
      .req      (bus.req[i]),
      .en       (bus.warp_en[i]),
      .is_cur   (idx_q == IDX_W'(i)),
      .elig     (elig[i]),
      .elig_acc (elig_acc[i])
    );
  end

  // Lowest set bit of v rotated right by p, mapped back to an absolute
  // index. Result is {found, idx}.
  function automatic logic [IDX_W:0] pick(input logic [NUM_WARP-1:0] v,
                                          input logic [IDX_W-1:0]    p);
    logic [IDX_W:0] j;
    logic           found;
    logic [IDX_W-1:0] w;
    found = 1'b0;
    w     = '0;
    for (int k = 0; k < NUM_WARP; k++) begin
      j = {1'b0, p} + (IDX_W+1)'(k);
      if (j >= NW) j = j - NW;
      if (!found && v[j[IDX_W-1:0]]) begin
        found = 1'b1;
        w     = j[IDX_W-1:0];
      end
    end
    return {found, w};
  endfunction

  // Pointer after an accept, and the two candidate winners.
  always_comb begin
    ptr_acc  = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    win_idle = pick(elig, ptr_q);
    win_acc  = pick(elig_acc, ptr_acc);
  end

  // Next-state / next-output logic; flush overrides everything.
  always_comb begin
    state_n = state;
    vld_n   = vld_q;
    grt_n   = grt_q;
    idx_n   = idx_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    if (bus.flush) begin
      state_n = IDLE;
      vld_n   = 1'b0;
      grt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_idle[IDX_W]) begin
            state_n = GRANT;
            vld_n   = 1'b1;
            idx_n   = win_idle[IDX_W-1:0];
            grt_n   = NUM_WARP'(1) << win_idle[IDX_W-1:0];
          end
        end
        GRANT: begin
          if (bus.grt_ready) begin
            cnt_n = cnt_q + 1'b1;
            ptr_n = ptr_acc;
            if (win_acc[IDX_W]) begin
              idx_n = win_acc[IDX_W-1:0];
              grt_n = NUM_WARP'(1) << win_acc[IDX_W-1:0];
            end else begin
              state_n = IDLE;
              vld_n   = 1'b0;
              grt_n   = '0;
              idx_n   = '0;
            end
          end else if (!elig[idx_q]) begin
            // requester withdrew before the issue stage took it
            state_n = IDLE;
            vld_n   = 1'b0;
            grt_n   = '0;
            idx_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vld_q <= 1'b0;
      grt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      vld_q <= vld_n;
      grt_q <= grt_n;
      idx_q <= idx_n;
      ptr_q <= ptr_n;
      cnt_q <= cnt_n;
    end
  end

  assign bus.grt_valid = vld_q;
  assign bus.grt       = grt_q;
  assign bus.grt_idx   = idx_q;
  assign bus.issue_cnt = cnt_q;

endmodule

// File: tb/tb_rr_warp_issue_arbiter.sv
// Bench for rr_warp_issue_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_rr_warp_issue_arbiter;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // behavioural model state
  bit m_vld;
  int m_idx, m_ptr, m_cnt;

  rr_warp_issue_arbiter_if #(.NUM_WARP(N), .IDX_W(3), .CNT_W(16)) bus ();

  rr_warp_issue_arbiter #(.NUM_WARP(N), .IDX_W(3), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int pick(input bit [N-1:0] e, input int p);
    for (int k = 0; k < N; k++)
      if (e[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_update();
    bit [N-1:0] e;
    int w;
    e = bus.req & bus.warp_en;
    if (bus.flush) m_vld = 0;
    else if (!m_vld) begin
      w = pick(e, m_ptr);
      if (w >= 0) begin m_vld = 1; m_idx = w; end
    end else if (bus.grt_ready) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_ptr = (m_idx + 1) % N;
      e[m_idx] = 1'b0;
      w = pick(e, m_ptr);
      if (w >= 0) m_idx = w; else m_vld = 0;
    end else if (!e[m_idx]) m_vld = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0; bus.warp_en = '1; bus.flush = 0; bus.grt_ready = 0;
    @(negedge clk);
    rst_n = 0;
    m_vld = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.grt_valid !== 1'b0 || bus.grt !== 8'h00 || bus.grt_idx !== 3'd0 || bus.issue_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b grt=%h idx=%0d cnt=%0d want 0/00/0/0",
               bus.grt_valid, bus.grt, bus.grt_idx, bus.issue_cnt);
    end
    bus.req = 8'h00;
    step();
    checks++;
    if (bus.grt_valid !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: valid=%b want 0", bus.grt_valid);
    end
  endtask

  task automatic test_basic_hold();
    do_reset();
    bus.req = 8'b0001_0100; bus.grt_ready = 0;
    step();
    checks++;
    if (bus.grt_valid !== 1'b1 || bus.grt !== 8'h04 || bus.grt_idx !== 3'd2) begin
      errors++;
      $display("FAIL basic_grant: valid=%b grt=%h idx=%0d want 1/04/2", bus.grt_valid, bus.grt, bus.grt_idx);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.grt_valid !== 1'b1 || bus.grt !== 8'h04 || bus.grt_idx !== 3'd2) begin
        errors++;
        $display("FAIL hold_c%0d: grt=%h idx=%0d want 04/2", c, bus.grt, bus.grt_idx);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req = 8'hFF; bus.grt_ready = 1;
    for (int n = 1; n <= 10; n++) begin
      step();
      checks++;
      if (bus.grt_valid !== 1'b1 || bus.grt_idx !== 3'((n - 1) % 8) || bus.issue_cnt !== 16'(n - 1)) begin
        errors++;
        $display("FAIL rr_step%0d: valid=%b idx=%0d cnt=%0d want 1/%0d/%0d",
                 n, bus.grt_valid, bus.grt_idx, bus.issue_cnt, (n - 1) % 8, n - 1);
      end
    end
    checks++;
    if (bus.issue_cnt !== 16'd9) begin
      errors++; $display("FAIL rr_cnt9: cnt=%0d want 9", bus.issue_cnt);
    end
  endtask

  task automatic test_mask_withdraw();
    do_reset();
    bus.req = 8'h08; bus.warp_en = 8'hF7;
    step();
    checks++;
    if (bus.grt_valid !== 1'b0) begin
      errors++; $display("FAIL mask_blocks: valid=%b want 0", bus.grt_valid);
    end
    bus.warp_en = 8'hFF;
    step();
    checks++;
    if (bus.grt_valid !== 1'b1 || bus.grt_idx !== 3'd3) begin
      errors++; $display("FAIL mask_enable: valid=%b idx=%0d want 1/3", bus.grt_valid, bus.grt_idx);
    end
    bus.req = 8'h00;
    step();
    checks++;
    if (bus.grt_valid !== 1'b0 || bus.grt !== 8'h00 || bus.issue_cnt !== 16'd0) begin
      errors++;
      $display("FAIL withdraw: valid=%b grt=%h cnt=%0d want 0/00/0", bus.grt_valid, bus.grt, bus.issue_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    bus.req = 8'h20;
    step();
    checks++;
    if (bus.grt_idx !== 3'd5 || bus.grt_valid !== 1'b1) begin
      errors++; $display("FAIL flush_setup: idx=%0d valid=%b want 5/1", bus.grt_idx, bus.grt_valid);
    end
    bus.flush = 1; bus.grt_ready = 1; bus.req = 8'hFF;
    step();
    checks++;
    if (bus.grt_valid !== 1'b0 || bus.grt !== 8'h00 || bus.issue_cnt !== 16'd0) begin
      errors++;
      $display("FAIL flush_vs_ready: valid=%b grt=%h cnt=%0d want 0/00/0", bus.grt_valid, bus.grt, bus.issue_cnt);
    end
    bus.flush = 0; bus.grt_ready = 0;
    step();
    checks++;
    if (bus.grt_valid !== 1'b1 || bus.grt_idx !== 3'd0) begin
      errors++; $display("FAIL flush_ptr: valid=%b idx=%0d want 1/0", bus.grt_valid, bus.grt_idx);
    end
  endtask

  task automatic test_back_to_back_single();
    bit [3:0] pat;
    do_reset();
    bus.req = 8'h02; bus.grt_ready = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      pat[c] = bus.grt_valid;
      if (bus.grt_valid === 1'b1) begin
        checks++;
        if (bus.grt_idx !== 3'd1) begin
          errors++; $display("FAIL single_idx_c%0d: idx=%0d want 1", c, bus.grt_idx);
        end
      end
    end
    checks++;
    if (pat !== 4'b0101 || bus.issue_cnt !== 16'd2) begin
      errors++; $display("FAIL single_pattern: valid seq(c3..c0)=%b cnt=%0d want 0101/2", pat, bus.issue_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 8'h40; bus.grt_ready = 1;
    step();                       // grant 6
    step();                       // accepted, ptr=7, back to idle
    bus.grt_ready = 0;
    step();                       // grant 6 again, held
    checks++;
    if (bus.grt_valid !== 1'b1 || bus.grt_idx !== 3'd6 || bus.issue_cnt !== 16'd1) begin
      errors++;
      $display("FAIL areset_setup: valid=%b idx=%0d cnt=%0d want 1/6/1", bus.grt_valid, bus.grt_idx, bus.issue_cnt);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (bus.grt_valid !== 1'b0 || bus.grt !== 8'h00 || bus.issue_cnt !== 16'd0) begin
      errors++;
      $display("FAIL areset_immediate: valid=%b grt=%h cnt=%0d want 0/00/0", bus.grt_valid, bus.grt, bus.issue_cnt);
    end
    m_vld = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
    bus.req = 8'hFF;
    @(negedge clk);
    rst_n = 1;
    step();
    checks++;
    if (bus.grt_valid !== 1'b1 || bus.grt_idx !== 3'd0) begin
      errors++; $display("FAIL areset_first: valid=%b idx=%0d want 1/0", bus.grt_valid, bus.grt_idx);
    end
  endtask

  task automatic test_random();
    bit [N-1:0] exp_grt;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.req       = 8'($urandom);
      bus.warp_en   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      bus.grt_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      step();
      exp_grt = m_vld ? (8'h01 << m_idx) : 8'h00;
      checks++;
      if (bus.grt_valid !== m_vld || bus.grt !== exp_grt ||
          bus.grt_idx !== (m_vld ? 3'(m_idx) : 3'd0) || bus.issue_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL random_c%0d: valid=%b grt=%h idx=%0d cnt=%0d want %b/%h/%0d/%0d",
                 c, bus.grt_valid, bus.grt, bus.grt_idx, bus.issue_cnt,
                 m_vld, exp_grt, m_vld ? m_idx : 0, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_hold();
    test_round_robin();
    test_mask_withdraw();
    test_flush();
    test_back_to_back_single();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
